// File: rtl/c_drain.sv
// Streams the C result BRAM out row-major on a valid/ready stream, with a
// 2-entry skid buffer for the BRAM read latency and optional int8 requantization.
module c_drain #(
  parameter int unsigned N      = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              quant_en,
  input  logic [4:0]        quant_shift,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] c_address,
  input  logic [DATA_W-1:0] c_q,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned       Words    = N * N;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Words - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e state_q, state_d;

  logic              quant_en_q;
  logic [4:0]        shift_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] c_address_q;
  logic              inflight_q;

  logic [DATA_W-1:0] buf_data_q [2];
  logic [ADDR_W-1:0] buf_idx_q  [2];
  logic              wr_sel_q;
  logic              rd_sel_q;
  logic [1:0]        count_q;

  logic                     pop;
  logic                     push;
  logic                     issue;
  logic [ADDR_W-1:0]        issue_addr;
  logic [2:0]               occupancy;
  logic signed [DATA_W-1:0] shifted;
  logic [DATA_W-1:0]        push_data;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;
  // Entries held after this edge: buffered plus the read landing now, minus the beat leaving.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign c_address = c_address_q;
  assign out_data  = buf_data_q[rd_sel_q];
  assign out_index = buf_idx_q[rd_sel_q];
  assign out_last  = out_valid && (out_index == LastAddr);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (Words == 1) ? StFlush : StRun;
        end
      end
      StRun: begin
        if (issue && (rd_ptr_q == LastAddr)) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; the first read (address 0) is issued on the edge that accepts start.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;
    issue_addr = rd_ptr_q;
    unique case (state_q)
      StIdle: begin
        issue      = start;
        issue_addr = '0;
      end
      StRun: begin
        busy  = 1'b1;
        issue = (occupancy < 3'd2);
      end
      StFlush: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Requantization: arithmetic shift, then clamp to [-128, 127] and sign-extend.
  always_comb begin
    shifted   = $signed(c_q) >>> shift_q;
    push_data = c_q;
    if (quant_en_q) begin
      if (!shifted[DATA_W-1] && (|shifted[DATA_W-2:7])) begin
        push_data = {{(DATA_W-7){1'b0}}, 7'h7f};
      end else if (shifted[DATA_W-1] && !(&shifted[DATA_W-2:7])) begin
        push_data = {{(DATA_W-7){1'b1}}, 7'h00};
      end else begin
        push_data = shifted;
      end
    end
  end

  // Read issue; c_address_q doubles as the index tag of the read in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      quant_en_q  <= 1'b0;
      shift_q     <= 5'd0;
      rd_ptr_q    <= '0;
      c_address_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      if ((state_q == StIdle) && start) begin
        quant_en_q <= quant_en;
        shift_q    <= quant_shift;
      end
      inflight_q <= issue;
      if (issue) begin
        c_address_q <= issue_addr;
        rd_ptr_q    <= issue_addr + ADDR_W'(1);
      end
    end
  end

  // 2-entry FIFO
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_idx_q[i]  <= '0;
      end
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_data_q[wr_sel_q] <= push_data;
        buf_idx_q[wr_sel_q]  <= c_address_q;
        wr_sel_q             <= ~wr_sel_q;
      end
      if (pop) begin
        rd_sel_q <= ~rd_sel_q;
      end
      count_q <= occupancy[1:0];
    end
  end

endmodule

// File: tb/tb_c_drain.sv
// Scoreboard bench for c_drain: a reference model queues expected beats at start,
// independent monitors pop and compare each transfer (N=16 and N=4 instances).
module tb_c_drain;

  localparam int WORDS  = 256;
  localparam int WORDS4 = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  idx;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        quant_en = 1'b0;
  logic [4:0]  quant_shift = 5'd0;
  logic        out_ready = 1'b1;

  logic        busy, done, out_last, out_valid;
  logic [7:0]  c_address, out_index;
  logic [31:0] c_q, out_data;
  logic        busy4, done4, out_last4, out_valid4;
  logic [3:0]  c_address4, out_index4;
  logic [31:0] c_q4, out_data4;

  logic [31:0] mem  [WORDS];
  logic [31:0] mem4 [WORDS4];

  // The BRAM registers its address on the same edge the drain registers c_address.
  assign c_q  = mem[c_address];
  assign c_q4 = mem4[c_address4];

  c_drain #(.N(16), .ADDR_W(8), .DATA_W(32)) dut (
    .clock(clk), .reset(reset), .start(start), .quant_en(quant_en),
    .quant_shift(quant_shift), .busy(busy), .done(done), .c_address(c_address),
    .c_q(c_q), .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  c_drain #(.N(4), .ADDR_W(4), .DATA_W(32)) dut4 (
    .clock(clk), .reset(reset), .start(start4), .quant_en(quant_en),
    .quant_shift(quant_shift), .busy(busy4), .done(done4), .c_address(c_address4),
    .c_q(c_q4), .out_data(out_data4), .out_index(out_index4), .out_last(out_last4),
    .out_valid(out_valid4), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    passes = 0;
  int    checks = 0;
  int    done_count = 0;
  int    done4_count = 0;
  int    beats = 0;
  int    last_beat_cycle = -1;
  int    ready_mode = 0;
  int    d0 = 0;
  int    e0 = 0;
  bit    expect_done = 1'b0;
  beat_t exp_q[$];
  beat_t exp4_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Reference: floor(w / 2^sh) on the signed value, clamped to int8.
  function automatic logic [31:0] ref_word(input logic [31:0] w, input bit q, input int sh);
    longint v;
    if (!q) return w;
    v = longint'($signed(w));
    v = v >>> sh;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 32'(v);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom & 1);
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (expect_done) begin
        check("done_after_last", 64'(done), 64'(1));
        expect_done = 1'b0;
      end
      if (done) done_count++;
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got index %0d, required no beat", out_index);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({out_data, out_index, out_last}), 64'(e));
          if (out_last) begin
            last_beat_cycle = cyc;
            expect_done = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (done4) done4_count++;
      if (out_valid4 && out_ready) begin
        if (exp4_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat4: got index %0d, required no beat", out_index4);
        end else begin
          e = exp4_q.pop_front();
          check("beat4", 64'({out_data4, 8'(out_index4), out_last4}), 64'(e));
        end
      end
    end
  end

  task automatic start_drain(input bit qen, input int sh);
    for (int i = 0; i < WORDS; i++)
      exp_q.push_back('{data: ref_word(mem[i], qen, sh), idx: 8'(i), last: (i == WORDS - 1)});
    d0 = done_count;
    @(posedge clk);
    #1;
    quant_en = qen;
    quant_shift = 5'(sh);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
    quant_en = ~qen;
    quant_shift = 5'($urandom);
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'(1));
    check("addr_after_start", 64'(c_address), 64'(0));
    check("valid_not_yet", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("first_valid", 64'(out_valid), 64'(1));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_count == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", 64'(done_count != d0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check("single_done", 64'(done_count - d0), 64'(1));
    check("busy_idle", 64'(busy), 64'(0));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic wait_beats(input int b0, input int target);
    int n = 0;
    while ((beats - b0) < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("beat_target", 64'((beats - b0) >= target), 64'(1));
  endtask

  initial begin
    int b0;
    int d4;
    int n;
    for (int i = 0; i < WORDS; i++) mem[i] = 32'(i);
    for (int i = 0; i < WORDS4; i++) mem4[i] = $urandom;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_last", 64'(out_last), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_index", 64'(out_index), 64'(0));
    check("rst_addr", 64'(c_address), 64'(0));
    #1 reset = 1'b0;

    // Full-rate drain: last beat exactly WORDS cycles after the start edge.
    ready_mode = 0;
    start_drain(1'b0, 0);
    wait_done(2000);
    check("last_beat_cycle", 64'(last_beat_cycle), 64'(e0 + WORDS));

    // Random backpressure.
    ready_mode = 1;
    start_drain(1'b0, 0);
    wait_done(4000);

    // Requantization corner values, then random words and shifts.
    mem[0] = 32'h0000_1234;
    mem[1] = 32'h0000_0050;
    start_drain(1'b1, 4);
    wait_done(4000);
    mem[0] = 32'hFFFF_FC18;  // -1000
    mem[1] = 32'hFFFF_FFEC;  // -20
    start_drain(1'b1, 2);
    wait_done(4000);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
      start_drain(r != 0, int'($urandom_range(0, 31)));
      wait_done(4000);
    end

    // Second start mid-drain is ignored.
    for (int i = 0; i < WORDS; i++) mem[i] = 32'(i);
    b0 = beats;
    start_drain(1'b0, 0);
    wait_beats(b0, 10);
    #1;
    quant_en = 1'b1;
    quant_shift = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(4000);

    // Reset mid-drain, then a clean drain.
    ready_mode = 0;
    b0 = beats;
    start_drain(1'b0, 0);
    wait_beats(b0, 100);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_valid", 64'(out_valid), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_count - d0), 64'(0));
    ready_mode = 1;
    start_drain(1'b0, 0);
    wait_done(4000);

    // N=4 instance.
    for (int i = 0; i < WORDS4; i++)
      exp4_q.push_back('{data: mem4[i], idx: 8'(i), last: (i == WORDS4 - 1)});
    d4 = done4_count;
    @(posedge clk);
    #1;
    quant_en = 1'b0;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    n = 0;
    while (done4_count == d4 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("n4_single_done", 64'(done4_count - d4), 64'(1));
    check("n4_queue_drained", 64'(exp4_q.size()), 64'(0));
    check("n4_busy_idle", 64'(busy4), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/c_drain.md
# c_drain

Streams the 32-bit result matrix C out of the C result BRAM once the compute unit has finished. It drives read-only port B of that BRAM, absorbs the one-cycle BRAM read latency with a 2-entry buffer, and presents results row-major on a valid/ready stream. An optional requantization path shifts and saturates each result to int8.

## Interface
- N, 16: matrix dimension; words = N*N, which must be ≤ 2^ADDR_W.
- ADDR_W, 8: BRAM address width.
- DATA_W, 32: result word width.

- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  one-cycle pulse that begins a drain; ignored while busy=1.
- quant_en  in  1  sampled at start; 1 selects int8 requantization.
- quant_shift  in  5  sampled at start; arithmetic right-shift amount.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last word is accepted.
- c_address  out  ADDR_W  BRAM port-B read address (port B write enable is tied 0 at top level).
- c_q  in  DATA_W  BRAM port-B read data; valid the cycle after the address is presented.
- out_data  out  DATA_W  result word, or sign-extended int8 when quantizing.
- out_index  out  ADDR_W  linear index (row*N+col) of out_data.
- out_last  out  1  high with the beat at index N*N-1.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a transfer occurs when out_valid and out_ready are both high.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE, start=1 → RUN: latch quant_en and quant_shift; clear rd_ptr, buffer count and in-flight flag.
  - RUN: issue a read (c_address=rd_ptr, rd_ptr++) in any cycle where count + inflight − (pop this cycle) < 2. After issuing address N*N−1 → FLUSH.
  - FLUSH: issue no reads; wait until the buffer is empty and nothing is in flight, with the last beat accepted → DONE.
  - DONE: done=1 for one cycle → IDLE.
- In-flight read: c_q is captured into the buffer one cycle after issue, tagged with its index.
- Buffer: 2-entry FIFO. The head drives out_data, out_index and out_last. out_valid = (count > 0). Pop on transfer. Push and pop may occur in the same cycle.
- Backpressure: no word is lost or duplicated; order is strictly ascending index.
- Requantization (quant_en=1): y = c_q >>> quant_shift (arithmetic, truncation toward −inf).
  - Saturate to [−128, 127].
  - out_data = sign-extended 32-bit y.
  - Applied at buffer push. out_index is unaffected.
- quant_en=0: out_data = c_q unmodified.
- start while busy=1 is ignored, and latched parameters do not change.
- c_address holds its last value when no read is issued. The BRAM is never written.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, out_index=0, c_address=0; FSM=IDLE.
- Reset asserted mid-drain: on the next edge, all outputs take their reset values and buffer contents are discarded. No done pulse is produced.
- start accepted at edge E0:
  - busy=1 and c_address=0 after E0.
  - First buffered word, with out_valid=1, after E0+1 (latency 2 edges from start).
- With out_ready held high: one beat per cycle, N*N consecutive beats. The last beat (out_last=1) is on cycle E0+1+N*N−1.
- done pulses in the cycle after the edge that accepts the last beat; busy falls on that same edge.
- After done, a new start is accepted in the following cycle (IDLE).

## Test plan
- BRAM preloaded with C[i]=i, N=16, out_ready=1, quant_en=0, start pulse → 256 consecutive beats. Data and index equal 0..255, out_last only on index 255, first out_valid 2 edges after start, done 1 cycle after the last beat.
- Same preload with out_ready toggled pseudo-randomly (about 50%) → 256 beats in order, no gaps or duplicates in out_index, data matches, buffer never overflows.
- quant_en=1, shift=4: word 0x00001234 → 0x0000007F; 0x00000050 → 0x00000005. shift=2: word −1000 → 0xFFFFFF80; word −20 → 0xFFFFFFFB.
- Second start pulse at beat 10 of an active drain → ignored; stream continues unchanged; exactly one done pulse.
- reset asserted at beat 100 → out_valid=0 and busy=0 next cycle, no done. A fresh start then drains from index 0 correctly.
- N=4 build → 16 beats, out_last at index 15, c_address never exceeds 15.
